// File: rtl/hb_tq_sched_pkg.sv
// Shared types and defaults for the task queue scheduler.
// FSM state enum, default parameters, stats counter width.
package hb_tq_sched_pkg;

  localparam int DEF_NUM_PROD    = 4;
  localparam int DEF_NUM_WORKERS = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_CREDITS     = 2;
  localparam int STATS_W         = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/hb_rr_arbiter.sv
// Combinational round-robin arbiter: first req at or after ptr wins.
// Ports: req[N], ptr -> grant[N] one-hot, grant_idx, any.
module hb_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/hb_task_queue_sched.sv
// Producer push arbiter and credit-based worker dispatcher around one task queue.
// Ports: clk, reset, prod_*, q_*, wk_*, busy, push_count, disp_count.
// Optional stats counters are built when HB_TQ_SCHED_STATS_EN is defined.
module hb_task_queue_sched
  import hb_tq_sched_pkg::*;
#(
  parameter int NUM_PROD    = DEF_NUM_PROD,
  parameter int NUM_WORKERS = DEF_NUM_WORKERS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CREDITS     = DEF_CREDITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PROD-1:0]        prod_valid,
  input  logic [NUM_PROD*DATA_W-1:0] prod_data,
  output logic [NUM_PROD-1:0]        prod_ready,
  output logic                       q_push_req,
  output logic [DATA_W-1:0]          q_data_in,
  input  logic                       q_full,
  input  logic                       q_valid_out,
  input  logic [DATA_W-1:0]          q_data_out,
  output logic                       q_pop_req,
  output logic [NUM_WORKERS-1:0]     wk_valid,
  output logic [DATA_W-1:0]          wk_data,
  input  logic [NUM_WORKERS-1:0]     wk_done,
  output logic                       busy,
  output logic [STATS_W-1:0]         push_count,
  output logic [STATS_W-1:0]         disp_count
);

  localparam int PW = $clog2(NUM_PROD);
  localparam int WW = $clog2(NUM_WORKERS);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [PW-1:0]          prod_ptr;
  logic [NUM_PROD-1:0]    p_req;
  logic [NUM_PROD-1:0]    p_grant;
  logic [PW-1:0]          p_idx;
  logic                   p_any;

  logic [WW-1:0]          wk_ptr;
  logic [NUM_WORKERS-1:0] eligible;
  logic [NUM_WORKERS-1:0] w_req;
  logic [NUM_WORKERS-1:0] w_grant;
  logic [WW-1:0]          w_idx;
  logic                   w_any;

  logic [CW-1:0]          credit [NUM_WORKERS];
  logic [NUM_WORKERS-1:0] wk_sel;

  sched_state_e state, state_n;

  // push side
  assign p_req = q_full ? '0 : prod_valid;

  hb_rr_arbiter #(.N(NUM_PROD)) u_prod_arb (
    .req       (p_req),
    .ptr       (prod_ptr),
    .grant     (p_grant),
    .grant_idx (p_idx),
    .any       (p_any)
  );

  assign prod_ready = p_grant;
  assign q_push_req = p_any;
  assign q_data_in  = p_any
    ? prod_data[int'(p_idx)*DATA_W +: DATA_W]
    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_ptr <= '0;
    end else if (p_any) begin
      prod_ptr <= (p_idx == PW'(NUM_PROD - 1))
        ? '0 : p_idx + PW'(1);
    end
  end

  // pop side: eligibility uses registered credits only
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WORKERS; w++) begin
      eligible[w] = (credit[w] != '0);
    end
  end

  assign w_req = q_valid_out ? eligible : '0;

  hb_rr_arbiter #(.N(NUM_WORKERS)) u_wk_arb (
    .req       (w_req),
    .ptr       (wk_ptr),
    .grant     (w_grant),
    .grant_idx (w_idx),
    .any       (w_any)
  );

  assign q_pop_req = w_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wk_ptr  <= '0;
      wk_sel  <= '0;
      wk_data <= '0;
    end else if (w_any) begin
      wk_ptr  <= (w_idx == WW'(NUM_WORKERS - 1))
        ? '0 : w_idx + WW'(1);
      wk_sel  <= w_grant;
      wk_data <= q_data_out;
    end
  end

  // dispatch and done on one worker cancel; done at full is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WORKERS; w++) begin
        credit[w] <= CMAX;
      end
    end else begin
      for (int w = 0; w < NUM_WORKERS; w++) begin
        if (w_grant[w] && !wk_done[w]) begin
          credit[w] <= credit[w] - CW'(1);
        end else if (!w_grant[w] && wk_done[w]
                     && credit[w] != CMAX) begin
          credit[w] <= credit[w] + CW'(1);
        end
      end
    end
  end

  // dispatch FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wk_valid = '0;
    unique case (state)
      IDLE: begin
        if (w_any) state_n = ISSUE;
      end
      ISSUE: begin
        wk_valid = wk_sel;
        state_n  = w_any ? ISSUE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ISSUE);
    for (int w = 0; w < NUM_WORKERS; w++) begin
      if (credit[w] != CMAX) busy = 1'b1;
    end
  end

`ifdef HB_TQ_SCHED_STATS_EN
  logic [STATS_W-1:0] push_cnt;
  logic [STATS_W-1:0] disp_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_cnt <= '0;
      disp_cnt <= '0;
    end else begin
      push_cnt <= push_cnt + STATS_W'(q_push_req);
      disp_cnt <= disp_cnt + STATS_W'(q_pop_req);
    end
  end

  assign push_count = push_cnt;
  assign disp_count = disp_cnt;
`else
  assign push_count = '0;
  assign disp_count = '0;
`endif

endmodule
